// File: rtl/alu_pkg.sv
// Shared opcode encoding and FLAGS bit positions for the ALU core.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAdd  = 4'h0,
    OpAdc  = 4'h1,
    OpSub  = 4'h2,
    OpSbc  = 4'h3,
    OpAnd  = 4'h4,
    OpOr   = 4'h5,
    OpXor  = 4'h6,
    OpNot  = 4'h7,
    OpShl  = 4'h8,
    OpShr  = 4'h9,
    OpAsr  = 4'hA,
    OpRol  = 4'hB,
    OpRor  = 4'hC,
    OpInc  = 4'hD,
    OpDec  = 4'hE,
    OpPass = 4'hF
  } alu_op_e;

  localparam int unsigned FlagC  = 0;
  localparam int unsigned FlagZ  = 1;
  localparam int unsigned FlagN  = 2;
  localparam int unsigned FlagV  = 3;
  localparam int unsigned FlagP  = 4;
  localparam int unsigned FlagH  = 5;
  localparam int unsigned FlagsW = 8;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor with carry (borrow), half-carry and signed overflow outputs.
module alu_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             hc,
  output logic             ovf
);

  logic [WIDTH-1:0] b_x;
  logic             cin_x;
  logic [WIDTH:0]   full;
  logic [4:0]       low;

  // Subtract as a + ~b + ~borrow_in; carry-outs invert back into borrows.
  assign b_x   = sub ? ~b : b;
  assign cin_x = cin ^ sub;
  assign full  = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, cin_x};
  assign low   = {1'b0, a[3:0]} + {1'b0, b_x[3:0]} + {4'b0000, cin_x};

  assign sum  = full[WIDTH-1:0];
  assign cout = full[WIDTH] ^ sub;
  assign hc   = low[4] ^ sub;
  assign ovf  = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_core.sv
// Combinational ALU with optional registered carry for ADC/SBC chaining.
// Define ALU_CARRY_CHAIN_EN to build the stored-carry register.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        ALU_CTL,
  input  logic [WIDTH-1:0]  A,
  input  logic [WIDTH-1:0]  B,
  output logic [WIDTH-1:0]  Z,
  output logic [FlagsW-1:0] FLAGS
);

  alu_op_e          op;
  logic             cq_q;
  logic [WIDTH-1:0] as_b;
  logic             as_cin;
  logic             as_sub;
  logic [WIDTH-1:0] as_sum;
  logic             as_cout;
  logic             as_hc;
  logic             as_ovf;
  logic             c;
  logic             v;
  logic             h;

  assign op = alu_op_e'(ALU_CTL);

  always_comb begin
    as_b   = B;
    as_cin = 1'b0;
    as_sub = 1'b0;
    unique case (op)
      OpAdc:   as_cin = cq_q;
      OpSub:   as_sub = 1'b1;
      OpSbc: begin
        as_sub = 1'b1;
        as_cin = cq_q;
      end
      OpInc:   as_b = {{(WIDTH-1){1'b0}}, 1'b1};
      OpDec: begin
        as_b   = {{(WIDTH-1){1'b0}}, 1'b1};
        as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  alu_addsub #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a   (A),
    .b   (as_b),
    .cin (as_cin),
    .sub (as_sub),
    .sum (as_sum),
    .cout(as_cout),
    .hc  (as_hc),
    .ovf (as_ovf)
  );

  always_comb begin
    Z = '0;
    c = 1'b0;
    v = 1'b0;
    h = 1'b0;
    unique case (op)
      OpAdd, OpAdc, OpSub, OpSbc, OpInc, OpDec: begin
        Z = as_sum;
        c = as_cout;
        v = as_ovf;
        h = as_hc;
      end
      OpAnd:  Z = A & B;
      OpOr:   Z = A | B;
      OpXor:  Z = A ^ B;
      OpNot:  Z = ~A;
      OpShl: begin
        Z = {A[WIDTH-2:0], 1'b0};
        c = A[WIDTH-1];
      end
      OpShr: begin
        Z = {1'b0, A[WIDTH-1:1]};
        c = A[0];
      end
      OpAsr: begin
        Z = {A[WIDTH-1], A[WIDTH-1:1]};
        c = A[0];
      end
      OpRol: begin
        Z = {A[WIDTH-2:0], A[WIDTH-1]};
        c = A[WIDTH-1];
      end
      OpRor: begin
        Z = {A[0], A[WIDTH-1:1]};
        c = A[0];
      end
      OpPass: Z = B;
      default: ;
    endcase
  end

  always_comb begin
    FLAGS        = '0;
    FLAGS[FlagC] = c;
    FLAGS[FlagZ] = (Z == '0);
    FLAGS[FlagN] = Z[WIDTH-1];
    FLAGS[FlagV] = v;
    FLAGS[FlagP] = ^Z;
    FLAGS[FlagH] = h;
  end

`ifdef ALU_CARRY_CHAIN_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_q <= 1'b0;
    end else begin
      cq_q <= c;
    end
  end
`else
  // No stored carry: ADC/SBC degenerate to ADD/SUB, clock and reset are idle.
  logic unused_clk_rst;
  assign cq_q           = 1'b0;
  assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Directed vector bench for alu_core, plus carry-chain and async-reset sequences.
module tb_alu_core;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] alu_ctl;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] z;
  logic [7:0] flags;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] z;
    logic [7:0] f;
  } vec_t;

  vec_t vecs[23];

  alu_core #(
    .WIDTH(8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ALU_CTL(alu_ctl),
    .A      (a),
    .B      (b),
    .Z      (z),
    .FLAGS  (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] exp_z, input logic [7:0] exp_f);
    total++;
    if (z !== exp_z) begin
      bad++;
      $display("FAIL %s Z: got %h want %h", name, z, exp_z);
    end
    total++;
    if (flags !== exp_f) begin
      bad++;
      $display("FAIL %s FLAGS: got %h want %h", name, flags, exp_f);
    end
  endtask

  task automatic drive(input logic [3:0] op, input logic [7:0] va, input logic [7:0] vb);
    alu_ctl = op;
    a       = va;
    b       = vb;
  endtask

  initial begin
    vecs[0]  = '{4'h0, 8'hFF, 8'h01, 8'h00, 8'h23};
    vecs[1]  = '{4'h2, 8'h80, 8'h01, 8'h7F, 8'h38};
    vecs[2]  = '{4'hC, 8'h01, 8'h00, 8'h80, 8'h15};
    vecs[3]  = '{4'hA, 8'h80, 8'h00, 8'hC0, 8'h04};
    vecs[4]  = '{4'h4, 8'hF0, 8'h0F, 8'h00, 8'h02};
    vecs[5]  = '{4'hF, 8'h00, 8'hAA, 8'hAA, 8'h04};
    vecs[6]  = '{4'h0, 8'h7F, 8'h01, 8'h80, 8'h3C};
    vecs[7]  = '{4'h2, 8'h00, 8'h01, 8'hFF, 8'h25};
    vecs[8]  = '{4'h5, 8'h12, 8'h21, 8'h33, 8'h00};
    vecs[9]  = '{4'h6, 8'hFF, 8'h0F, 8'hF0, 8'h04};
    vecs[10] = '{4'h7, 8'h55, 8'h00, 8'hAA, 8'h04};
    vecs[11] = '{4'h8, 8'h81, 8'h00, 8'h02, 8'h11};
    vecs[12] = '{4'h9, 8'h81, 8'h00, 8'h40, 8'h11};
    vecs[13] = '{4'hB, 8'h81, 8'h00, 8'h03, 8'h01};
    vecs[14] = '{4'hD, 8'hFF, 8'h00, 8'h00, 8'h23};
    vecs[15] = '{4'hE, 8'h00, 8'h00, 8'hFF, 8'h25};
    vecs[16] = '{4'hD, 8'h7F, 8'h00, 8'h80, 8'h3C};
    vecs[17] = '{4'hE, 8'h80, 8'h00, 8'h7F, 8'h38};
    vecs[18] = '{4'h1, 8'h01, 8'h01, 8'h02, 8'h10};
    vecs[19] = '{4'h3, 8'h05, 8'h03, 8'h02, 8'h10};
    vecs[20] = '{4'hA, 8'h41, 8'h00, 8'h20, 8'h11};
    vecs[21] = '{4'h2, 8'h05, 8'h05, 8'h00, 8'h02};
    vecs[22] = '{4'h0, 8'h08, 8'h08, 8'h10, 8'h30};

    rst_n = 1'b0;
    drive(4'h1, 8'h00, 8'h00);
    #2;
    check("reset_adc", 8'h00, 8'h02);

    // Table runs with reset held, so the stored carry stays 0 across edges.
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b);
      #3;
      check($sformatf("vec%0d", i), vecs[i].z, vecs[i].f);
    end

    @(negedge clk);
    rst_n = 1'b1;

    // ADD producing carry, then ADC consumes it on the next cycle.
    drive(4'h0, 8'hFF, 8'h01);
    #1;
    check("chain_add", 8'h00, 8'h23);
    @(posedge clk);
    #1;
    drive(4'h1, 8'h00, 8'h00);
    #1;
`ifdef ALU_CARRY_CHAIN_EN
    check("chain_adc", 8'h01, 8'h10);
`else
    check("chain_adc", 8'h00, 8'h02);
`endif

    // SUB producing borrow, then SBC consumes it.
    @(negedge clk);
    drive(4'h2, 8'h00, 8'h01);
    #1;
    check("chain_sub", 8'hFF, 8'h25);
    @(posedge clk);
    #1;
    drive(4'h3, 8'h05, 8'h03);
    #1;
`ifdef ALU_CARRY_CHAIN_EN
    check("chain_sbc", 8'h01, 8'h10);
`else
    check("chain_sbc", 8'h02, 8'h10);
`endif

    // Carry set, then an async reset pulse between edges must clear it at once.
    @(negedge clk);
    drive(4'h0, 8'hFF, 8'h01);
    @(posedge clk);
    #1;
    drive(4'h1, 8'h01, 8'h01);
    #1;
`ifdef ALU_CARRY_CHAIN_EN
    check("pre_reset_adc", 8'h03, 8'h00);
`else
    check("pre_reset_adc", 8'h02, 8'h10);
`endif
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_adc", 8'h02, 8'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded limit");
    $fatal(1);
  end

endmodule

// File: doc/alu_core.md
ALU_CORE -- requirements
Module: alu_core

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; only 8 is required to be supported.
REQ-002 SHALL have port clk, input, 1, single clock; rising edge active.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port ALU_CTL, input, 4, opcode.
REQ-005 SHALL have port A, input, WIDTH, operand A.
REQ-006 SHALL have port B, input, WIDTH, operand B.
REQ-007 SHALL have port Z, output, WIDTH, result.
REQ-008 SHALL have port FLAGS, output, 8, status flags.
- FLAGS bit order: [0] C, [1] ZF, [2] N, [3] V, [4] P, [5] H, [7:6] constant 0.

Function
REQ-009 SHALL compute Z and FLAGS combinationally from ALU_CTL, A, B and stored carry Cq, with zero-cycle latency.
REQ-010 SHALL decode opcodes as follows:
- 0 ADD: A+B
- 1 ADC: A+B+Cq
- 2 SUB: A-B
- 3 SBC: A-B-Cq
- 4 AND, 5 OR, 6 XOR
- 7 NOT: ~A
- 8 SHL: A<<1
- 9 SHR: logical A>>1
- A ASR: arithmetic A>>1
- B ROL: rotate A left by 1
- C ROR: rotate A right by 1
- D INC: A+1
- E DEC: A-1
- F PASS: B
REQ-011 SHALL wrap all arithmetic modulo 2^WIDTH.
REQ-012 SHALL set C as follows:
- ADD/ADC/INC: carry-out.
- SUB/SBC/DEC: borrow (1 when the unsigned minuend is less than the subtrahend plus borrow-in).
- SHL/ROL: A[7].
- SHR/ASR/ROR: A[0].
- Every other opcode: 0.
REQ-013 SHALL set ZF=1 when Z==0, and N=Z[7], for all opcodes.
REQ-014 SHALL set V as signed two's-complement overflow for opcodes 0-3 and D-E, and 0 for all other opcodes.
REQ-015 SHALL set P as the XOR-reduction of Z (1 = odd number of ones).
REQ-016 SHALL set H as the carry (add) or borrow (sub) out of bit 3 for opcodes 0-3 and D-E, and 0 otherwise.
REQ-017 SHALL hold FLAGS[7:6] at 0 for all opcodes.
REQ-018 SHALL load Cq from FLAGS[0] on every rising clk edge; ADC/SBC therefore chain on the previous cycle's carry.
REQ-019 SHALL produce fully known (no X) outputs for any known inputs, including unused flag bits.
- Boundary: ADD 0xFF+0x01 gives Z=0x00, C=1, ZF=1, H=1.
- Boundary: SUB 0x80-0x01 gives Z=0x7F, V=1.

Reset
REQ-020 SHALL clear Cq to 0 asynchronously while rst_n=0.
REQ-021 SHALL keep Z/FLAGS combinational during reset, evaluated with Cq=0.
REQ-022 SHALL apply reset asserted mid-chain immediately, so the next ADC uses carry-in 0.

Configuration
REQ-023 SHALL compile the carry chain in when macro ALU_CARRY_CHAIN_EN is defined: Cq register present, ADC/SBC use Cq.
REQ-024 SHALL, without ALU_CARRY_CHAIN_EN, omit the Cq register, make ADC behave identically to ADD and SBC identically to SUB, and leave clk/rst_n unused.

Structure
REQ-025 SHALL take opcode enum (16 values) and flag bit-index localparams from shared package alu_pkg.
REQ-026 SHALL use one sub-module, alu_addsub, for ADD/ADC/SUB/SBC/INC/DEC.
- alu_addsub: inputs a, b, cin, sub; outputs sum, cout, hc, ovf.
REQ-027 SHALL implement shifts, rotates and logic ops inline in alu_core.

Verification
REQ-028 SHALL cover: ADD A=0xFF B=0x01 -> Z=0x00, FLAGS=0x23 (C, ZF, H).
REQ-029 SHALL cover: SUB A=0x80 B=0x01 -> Z=0x7F, FLAGS=0x38 (V, P, H).
REQ-030 SHALL cover: ADD 0xFF+0x01, clock edge, then ADC A=0x00 B=0x00 -> Z=0x01, FLAGS=0x10; without ALU_CARRY_CHAIN_EN -> Z=0x00, FLAGS=0x02.
REQ-031 SHALL cover: ROR A=0x01 -> Z=0x80, FLAGS=0x15; ASR A=0x80 -> Z=0xC0, FLAGS=0x04.
REQ-032 SHALL cover: AND A=0xF0 B=0x0F -> Z=0x00, FLAGS=0x02; PASS B=0xAA -> Z=0xAA, FLAGS=0x04.
REQ-033 SHALL cover: carry set, rst_n pulsed low asynchronously, then ADC 0x01+0x01 -> Z=0x02, FLAGS=0x10.
